// File: rtl/wb_reg_file.sv
// Write-back stage and 32-entry architectural register file.
// Selects the write-back value (load data or ALU result), commits it on the
// rising edge, serves two combinational ID-stage read ports with a
// same-cycle bypass, and exposes a registered debug read port plus a
// saturating count of committed writes.
module wb_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        WB,
  input  logic [DATA_W-1:0] read_data,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [ADDR_W-1:0] RegDst_address,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_en,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  write_count
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Write-back value select and commit qualification. Register 0 is never
  // written, and no commit is possible while reset is held.
  always_comb begin
    wb_data = WB[0] ? read_data : ALU_result;
    wb_en   = WB[1] && (RegDst_address != '0) && rst_n;
  end

  // Read port A: r0 reads zero, then the in-flight write wins, then the array.
  always_comb begin
    // NOTE: assign a default first so every path drives the output; a
    // missing branch in always_comb would otherwise infer a latch.
    rs_data = regs[rs_addr];
    if (rs_addr == '0)
      rs_data = '0;
    else if (wb_en && (rs_addr == RegDst_address))
      rs_data = wb_data;
  end

  // Read port B: same priority as port A; both may bypass in one cycle.
  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == '0)
      rt_data = '0;
    else if (wb_en && (rt_addr == RegDst_address))
      rt_data = wb_data;
  end

  // Register array: cleared by reset, one write per edge when wb_en is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is architecturally visible and must read zero right
      // after reset, so it is reset explicitly; that forces flops rather than
      // a RAM macro, which is acceptable at 32 entries.
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wb_en) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every always_ff samples pre-edge values and ordering cannot matter.
      regs[RegDst_address] <= wb_data;
    end
  end

  // Debug read: registered, sampled from the array before this edge's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dbg_data <= '0;
    else
      dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

  // Committed-write counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      write_count <= '0;
    else if (wb_en && (write_count != '1))
      write_count <= write_count + 1'b1;
  end

endmodule
